// File: rtl/onchip_mem_test_master.sv
// Avalon-MM memory self-test initiator: fills a word range with seed+i, reads it back,
// and reports the mismatch count and the first failing address.
module onchip_mem_test_master #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int ERR_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    input  logic [DATA_W-1:0]     seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      error_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [ADDR_W-1:0]     m_address,
    output logic [DATA_W/8-1:0]   m_byteenable,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic [DATA_W-1:0]     m_writedata,
    input  logic [DATA_W-1:0]     m_readdata,
    output logic                  m_clken
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W:0]  IDX_ONE = 1;
    localparam logic [ERR_W-1:0] ERR_ONE = 1;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [ADDR_W:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]     seed_q, seed_d;
    logic [ADDR_W:0]       idx_q, idx_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic [ADDR_W-1:0]     ferr_q, ferr_d;
    logic                  pass_q, pass_d;
    logic                  cs_q, cs_d, wr_q, wr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   be_q, be_d;
    logic                  vld_q, vld_d;
    logic [DATA_W-1:0]     exp_q, exp_d;
    logic [ADDR_W-1:0]     caddr_q, caddr_d;
    logic                  last;

    assign last = (idx_q == cnt_q - IDX_ONE);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (word_count == '0) ? S_DONE : S_WRITE;
            S_WRITE: if (last) state_d = S_READ;
            S_READ:  if (last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
        done = (state_q == S_DONE);
    end

    // Datapath next state; bus values are computed from the next FSM state so the
    // registered outputs line up with the cycle they belong to.
    always_comb begin
        base_d  = base_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        idx_d   = idx_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        pass_d  = pass_q;
        vld_d   = 1'b0;
        exp_d   = exp_q;
        caddr_d = caddr_q;
        if (state_q == S_IDLE && start) begin
            base_d = base_addr;
            cnt_d  = word_count;
            seed_d = seed;
            idx_d  = '0;
            err_d  = '0;
            ferr_d = '0;
            pass_d = 1'b0;
        end
        if (state_q == S_WRITE || state_q == S_READ)
            idx_d = last ? '0 : idx_q + IDX_ONE;
        if (state_q == S_READ) begin
            vld_d   = 1'b1;
            exp_d   = seed_q + DATA_W'(idx_q);
            caddr_d = addr_q;
        end
        if (vld_q && m_readdata != exp_q) begin
            if (err_q != '1) err_d = err_q + ERR_ONE;
            if (err_q == '0) ferr_d = caddr_q;
        end
        if (state_d == S_DONE) pass_d = (err_d == '0);
        cs_d    = (state_d == S_WRITE) || (state_d == S_READ);
        wr_d    = (state_d == S_WRITE);
        addr_d  = cs_d ? base_d + idx_d[ADDR_W-1:0] : '0;
        wdata_d = wr_d ? seed_d + DATA_W'(idx_d) : '0;
        be_d    = cs_d ? '1 : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q  <= '0;
            cnt_q   <= '0;
            seed_q  <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            pass_q  <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            vld_q   <= 1'b0;
            exp_q   <= '0;
            caddr_q <= '0;
        end else begin
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            pass_q  <= pass_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            vld_q   <= vld_d;
            exp_q   <= exp_d;
            caddr_q <= caddr_d;
        end
    end

    assign pass           = pass_q;
    assign error_count    = err_q;
    assign first_err_addr = ferr_q;
    assign m_chipselect   = cs_q;
    assign m_write        = wr_q;
    assign m_address      = addr_q;
    assign m_writedata    = wdata_q;
    assign m_byteenable   = be_q;
    assign m_clken        = 1'b1;
endmodule

// File: tb/tb_onchip_mem_test_master.sv
// Directed + randomized bench for onchip_mem_test_master with a 1-cycle-latency RAM model
// that can corrupt reads at selected addresses.
module tb_onchip_mem_test_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [12:0] word_count = '0;
    logic [31:0] seed = '0;
    logic        busy, done, pass;
    logic [15:0] error_count;
    logic [11:0] first_err_addr, m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect, m_write, m_clken;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;

    onchip_mem_test_master dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .error_count(error_count), .first_err_addr(first_err_addr),
        .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
        .m_write(m_write), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .m_clken(m_clken)
    );

    always #5 clk = ~clk;

    int nvec = 0, nmis = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM slave model
    logic [31:0] mem [4096];
    bit          fault [4096];
    always @(posedge clk) begin
        if (m_chipselect === 1'b1 && m_write === 1'b1) mem[m_address] <= m_writedata;
        if (m_chipselect === 1'b1 && m_write === 1'b0)
            m_readdata <= mem[m_address] ^ {31'b0, fault[m_address]};
    end

    // Bus/handshake monitor
    bit          mon_en = 0;
    logic [43:0] wq [$];
    logic [11:0] rq [$];
    int          done_cnt, done_cyc, busy_cnt, be_bad;
    always @(negedge clk) if (mon_en) begin
        if (m_chipselect === 1'b1 && m_write === 1'b1) wq.push_back({m_address, m_writedata});
        if (m_chipselect === 1'b1 && m_write !== 1'b1) rq.push_back(m_address);
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (busy === 1'b1) busy_cnt++;
        if (m_byteenable !== (m_chipselect ? 4'hF : 4'h0) || m_clken !== 1'b1) be_bad++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wq.delete(); rq.delete();
        done_cnt = 0; busy_cnt = 0; be_bad = 0; done_cyc = 0;
    endtask

    task automatic run(input logic [11:0] b, input int n, input logic [31:0] s,
                       input bit extra, input string tag);
        int k, t, exp_err, bad;
        logic [11:0] exp_first, a;
        logic [31:0] d;
        clear_mon();
        mon_en = 1;
        @(negedge clk);
        base_addr = b; word_count = 13'(n); seed = s; start = 1'b1;
        @(posedge clk); #1;
        k = cyc; start = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 10000) begin
            @(posedge clk); #1;
            t++;
            if (extra && t == 5) begin
                start = 1'b1; base_addr = ~b; word_count = 13'd3; seed = ~s;
            end else start = 1'b0;
        end
        repeat (3) @(negedge clk);
        mon_en = 0;
        chk({tag, ".timeout"}, (t < 10000) ? 1 : 0, 1);

        // Reference: word i at (b+i) mod 4096 holds s+i; a read mismatches iff faulted.
        exp_err = 0; exp_first = '0;
        for (int i = 0; i < n; i++) begin
            a = b + 12'(i);
            if (fault[a]) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        end
        chk({tag, ".latency"}, done_cyc - k + 1, (n == 0) ? 1 : 2 * n + 2);
        chk({tag, ".done_pulses"}, done_cnt, 1);
        chk({tag, ".busy_cycles"}, busy_cnt, (n == 0) ? 0 : 2 * n + 1);
        chk({tag, ".be_clken"}, be_bad, 0);
        chk({tag, ".n_writes"}, wq.size(), n);
        chk({tag, ".n_reads"}, rq.size(), n);
        bad = 0;
        for (int i = 0; i < n && i < wq.size() && i < rq.size(); i++) begin
            a = b + 12'(i);
            d = s + 32'(i);
            if (wq[i] !== {a, d} || rq[i] !== a) bad++;
        end
        chk({tag, ".trace"}, bad, 0);
        chk({tag, ".error_count"}, error_count, exp_err);
        chk({tag, ".first_err_addr"}, first_err_addr, exp_first);
        chk({tag, ".pass"}, pass, (exp_err == 0) ? 1 : 0);
    endtask

    initial begin
        logic [11:0] rb;
        int rn;
        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.pass", pass, 0);
        chk("rst.err", error_count, 0);
        chk("rst.ferr", first_err_addr, 0);
        chk("rst.bus", {m_chipselect, m_write, m_address, m_writedata, m_byteenable}, 0);
        chk("rst.clken", m_clken, 1);
        reset = 1'b0;

        run(12'h000, 16, 32'hA5A50000, 0, "clean16");
        run(12'hFFE, 4, 32'h0, 0, "wrap");

        fault[12'h005] = 1; fault[12'h009] = 1;
        run(12'h000, 16, $urandom, 0, "fault");
        chk("fault.count_direct", error_count, 2);
        chk("fault.first_direct", first_err_addr, 12'h005);
        fault[12'h005] = 0; fault[12'h009] = 0;

        run(12'($urandom), 0, $urandom, 0, "zero");

        // Reset in the middle of the read phase of a 64-word run
        @(negedge clk);
        base_addr = 12'h100; word_count = 13'd64; seed = $urandom; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (74) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort.busy", busy, 0);
        chk("abort.cs", m_chipselect, 0);
        chk("abort.done", done, 0);
        chk("abort.err", error_count, 0);
        clear_mon(); mon_en = 1;
        repeat (10) @(negedge clk);
        mon_en = 0;
        chk("abort.quiet", done_cnt + wq.size() + rq.size() + busy_cnt, 0);
        run(12'h100, 64, $urandom, 0, "after_abort");

        run(12'($urandom), 4096, 32'hFFFFFFFF, 1, "full4096");

        for (int j = 0; j < 3; j++) begin
            rb = 12'($urandom);
            rn = $urandom_range(1, 300);
            for (int f = 0; f < 3; f++) fault[rb + 12'($urandom_range(0, rn - 1))] = 1;
            run(rb, rn, $urandom, 0, "rand");
            for (int i = 0; i < 4096; i++) fault[i] = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
